ex_operand_stage: RTL

Execute-stage front end of the pipelined MIPS core: registers the decode-stage operands and control (ID/EX boundary), resolves data hazards by forwarding from the MEM and WB stages, and presents final `srcA`/`srcB`/`aluControl` to the ALU in the same cycle. It also detects load-use hazards, stalls decode and inserts a bubble. Sits directly between the register file / main decoder and the ALU.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/ex_operand_stage_if.sv | 75 +++++++
 rtl/ex_forward_unit.sv | 44 ++++
 rtl/ex_operand_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS pipeline execute front end.
//   - Default datapath / register-specifier widths
//   - ALU operation encodings (3-bit aluControl)
//   - fwd_sel_t : operand source selected by the forwarding unit
//   - REG_ZERO  : the hard-wired zero register specifier
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_DATA_W     = 32;
   localparam int ALU_OP_W       = 3;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_AND = 3'b000;
   localparam alu_op_t ALU_OR  = 3'b001;
   localparam alu_op_t ALU_ADD = 3'b010;
   localparam alu_op_t ALU_SUB = 3'b110;
   localparam alu_op_t ALU_SLT = 3'b111;

   localparam logic [DEF_REG_ADDR_W-1:0] REG_ZERO = '0;

   // Where an EX operand comes from: the registered register-file value,
   // the WB-stage result, or the MEM-stage ALU result.
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// -----------------------------------------------------------------------------
// ex_operand_stage_if
// Bundle of every non-clock signal of the execute operand stage.
//   Decode side  : validD, rd1D/rd2D, signImmD, rsD/rtD/rdD, aluControlD and
//                  the control bits aluSrcD, regDstD, regWriteD, memWriteD,
//                  memToRegD, branchD
//   Pipeline ctl : stallE (hold), flushE (bubble)
//   Forward ports: aluOutM/writeRegM/regWriteM, resultW/writeRegW/regWriteW
//   ALU side     : srcA, srcB, aluControl, writeDataE, writeRegE and the
//                  registered control regWriteE, memWriteE, memToRegE,
//                  branchE, validE; stallD back to fetch/decode
// modport slave  : the operand stage itself
// modport master : whatever drives decode/forwarding and consumes the ALU side
// -----------------------------------------------------------------------------
interface ex_operand_stage_if #(
   parameter int REG_ADDR_W = 5,
   parameter int DATA_W     = 32
);
   // decode stage
   logic                  validD;
   logic [DATA_W-1:0]     rd1D;
   logic [DATA_W-1:0]     rd2D;
   logic [DATA_W-1:0]     signImmD;
   logic [REG_ADDR_W-1:0] rsD;
   logic [REG_ADDR_W-1:0] rtD;
   logic [REG_ADDR_W-1:0] rdD;
   logic [2:0]            aluControlD;
   logic                  aluSrcD;
   logic                  regDstD;
   logic                  regWriteD;
   logic                  memWriteD;
   logic                  memToRegD;
   logic                  branchD;
   // pipeline control
   logic                  stallE;
   logic                  flushE;
   // forwarding sources
   logic [DATA_W-1:0]     aluOutM;
   logic [REG_ADDR_W-1:0] writeRegM;
   logic                  regWriteM;
   logic [DATA_W-1:0]     resultW;
   logic [REG_ADDR_W-1:0] writeRegW;
   logic                  regWriteW;
   // execute outputs
   logic [DATA_W-1:0]     srcA;
   logic [DATA_W-1:0]     srcB;
   logic [2:0]            aluControl;
   logic [DATA_W-1:0]     writeDataE;
   logic [REG_ADDR_W-1:0] writeRegE;
   logic                  regWriteE;
   logic                  memWriteE;
   logic                  memToRegE;
   logic                  branchE;
   logic                  validE;
   logic                  stallD;

   modport slave (
      input  validD, rd1D, rd2D, signImmD, rsD, rtD, rdD, aluControlD,
             aluSrcD, regDstD, regWriteD, memWriteD, memToRegD, branchD,
             stallE, flushE,
             aluOutM, writeRegM, regWriteM, resultW, writeRegW, regWriteW,
      output srcA, srcB, aluControl, writeDataE, writeRegE,
             regWriteE, memWriteE, memToRegE, branchE, validE, stallD
   );

   modport master (
      output validD, rd1D, rd2D, signImmD, rsD, rtD, rdD, aluControlD,
             aluSrcD, regDstD, regWriteD, memWriteD, memToRegD, branchD,
             stallE, flushE,
             aluOutM, writeRegM, regWriteM, resultW, writeRegW, regWriteW,
      input  srcA, srcB, aluControl, writeDataE, writeRegE,
             regWriteE, memWriteE, memToRegE, branchE, validE, stallD
   );

endinterface

// File: rtl/ex_forward_unit.sv
// -----------------------------------------------------------------------------
// ex_forward_unit
// Combinational forwarding selection for the two EX operands.
//   rsE, rtE                : source specifiers held in the EX registers
//   writeRegM, regWriteM    : MEM-stage write port
//   writeRegW, regWriteW    : WB-stage write port
//   forwardA, forwardB      : source select for rs (A) and rt (B)
// MEM wins over WB because it carries the younger result. Register $0 is
// never forwarded, so a write "to $0" can't corrupt a read of $0.
// -----------------------------------------------------------------------------
module ex_forward_unit
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] rsE,
   input  logic [REG_ADDR_W-1:0] rtE,
   input  logic [REG_ADDR_W-1:0] writeRegM,
   input  logic                  regWriteM,
   input  logic [REG_ADDR_W-1:0] writeRegW,
   input  logic                  regWriteW,
   output fwd_sel_t              forwardA,
   output fwd_sel_t              forwardB
);

   logic [REG_ADDR_W-1:0] srcReg [2];
   logic [1:0]            useMem;
   logic [1:0]            useWb;

   assign srcReg[0] = rsE;
   assign srcReg[1] = rtE;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         assign useMem[gi] = regWriteM && (writeRegM != '0) && (writeRegM == srcReg[gi]);
         assign useWb[gi]  = regWriteW && (writeRegW != '0) && (writeRegW == srcReg[gi]);
      end
   endgenerate

   assign forwardA = useMem[0] ? FWD_MEM : (useWb[0] ? FWD_WB : FWD_RF);
   assign forwardB = useMem[1] ? FWD_MEM : (useWb[1] ? FWD_WB : FWD_RF);

endmodule

// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus operand forwarding and load-use detection.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : ex_operand_stage_if.slave (decode inputs, stallE/flushE,
//           MEM/WB forwarding ports, ALU-facing outputs, stallD)
// Register update priority per edge: reset > bubble (flushE|stallD) >
// hold (stallE) > load. A bubble clears all control to 0, aluControl to ADD
// and all data/specifier registers to 0.
// srcA/srcB/writeDataE/stallD are combinational from the EX registers and the
// M/W inputs.
// -----------------------------------------------------------------------------
module ex_operand_stage
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W
) (
   input logic                clk,
   input logic                reset,
   ex_operand_stage_if.slave  bus
);

   // EX-stage registers
   logic                  validE;
   logic [DATA_W-1:0]     rd1E;
   logic [DATA_W-1:0]     rd2E;
   logic [DATA_W-1:0]     signImmE;
   logic [REG_ADDR_W-1:0] rsE;
   logic [REG_ADDR_W-1:0] rtE;
   logic [REG_ADDR_W-1:0] writeRegE;
   alu_op_t               aluControlE;
   logic                  aluSrcE;
   logic                  regWriteE;
   logic                  memWriteE;
   logic                  memToRegE;
   logic                  branchE;

   logic [REG_ADDR_W-1:0] writeRegD;
   logic                  stallD;
   logic                  bubble;
   fwd_sel_t              forwardA;
   fwd_sel_t              forwardB;
   logic [DATA_W-1:0]     srcAFwd;
   logic [DATA_W-1:0]     srcBFwd;

   // Destination is resolved before the register so rdD itself needn't be kept.
   assign writeRegD = bus.regDstD ? bus.rdD : bus.rtD;

   // A load in EX whose target is read by the instruction in decode: the data
   // isn't available until WB, so decode must wait one cycle. Gated by reset so
   // the request drops in the very cycle reset is raised.
   assign stallD = !reset && validE && memToRegE && (rtE != '0) && bus.validD
                   && ((rtE == bus.rsD) || (rtE == bus.rtD));

   // Bubble wins over stallE so a load-use stall can't deadlock against
   // downstream back-pressure.
   assign bubble = bus.flushE | stallD;

   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         validE      <= 1'b0;
         rd1E        <= '0;
         rd2E        <= '0;
         signImmE    <= '0;
         rsE         <= '0;
         rtE         <= '0;
         writeRegE   <= '0;
         aluControlE <= ALU_ADD;
         aluSrcE     <= 1'b0;
         regWriteE   <= 1'b0;
         memWriteE   <= 1'b0;
         memToRegE   <= 1'b0;
         branchE     <= 1'b0;
      end else if (!bus.stallE) begin
         validE      <= bus.validD;
         rd1E        <= bus.rd1D;
         rd2E        <= bus.rd2D;
         signImmE    <= bus.signImmD;
         rsE         <= bus.rsD;
         rtE         <= bus.rtD;
         writeRegE   <= writeRegD;
         aluControlE <= bus.aluControlD;
         aluSrcE     <= bus.aluSrcD;
         regWriteE   <= bus.regWriteD;
         memWriteE   <= bus.memWriteD;
         memToRegE   <= bus.memToRegD;
         branchE     <= bus.branchD;
      end
   end

   ex_forward_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_forward (
      .rsE       (rsE),
      .rtE       (rtE),
      .writeRegM (bus.writeRegM),
      .regWriteM (bus.regWriteM),
      .writeRegW (bus.writeRegW),
      .regWriteW (bus.regWriteW),
      .forwardA  (forwardA),
      .forwardB  (forwardB)
   );

   always_comb begin
      srcAFwd = rd1E;
      case (forwardA)
         FWD_MEM: srcAFwd = bus.aluOutM;
         FWD_WB:  srcAFwd = bus.resultW;
         default: srcAFwd = rd1E;
      endcase
   end

   always_comb begin
      srcBFwd = rd2E;
      case (forwardB)
         FWD_MEM: srcBFwd = bus.aluOutM;
         FWD_WB:  srcBFwd = bus.resultW;
         default: srcBFwd = rd2E;
      endcase
   end

   assign bus.srcA       = srcAFwd;
   assign bus.writeDataE = srcBFwd;
   assign bus.srcB       = aluSrcE ? signImmE : srcBFwd;
   assign bus.aluControl = aluControlE;
   assign bus.writeRegE  = writeRegE;
   assign bus.regWriteE  = regWriteE;
   assign bus.memWriteE  = memWriteE;
   assign bus.memToRegE  = memToRegE;
   assign bus.branchE    = branchE;
   assign bus.validE     = validE;
   assign bus.stallD     = stallD;

endmodule
